// File: rtl/servo_frame_sequencer_if.sv
// Command-side and transmitter-side handshake bundle for servo_frame_sequencer.
// master: command source / transmitter side; slave: the sequencer itself.
interface servo_frame_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  servo_id;
  logic [15:0] position;
  logic [15:0] move_time;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        frame_done;
  logic        frame_err;

  modport master (
    output cmd_valid, servo_id, position, move_time, tx_busy,
    input  cmd_ready, tx_wr, tx_data, frame_done, frame_err
  );

  modport slave (
    input  cmd_valid, servo_id, position, move_time, tx_busy,
    output cmd_ready, tx_wr, tx_data, frame_done, frame_err
  );
endinterface

// File: rtl/servo_frame_sequencer.sv
// Builds 10-byte servo move frames (55 55 ID LEN CMD POS TIME CHK) and feeds them to the UART transmitter.
// Optional feature: define SERVO_POS_CLAMP_EN to clamp the latched position to POS_MAX.
module servo_frame_sequencer #(
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned POS_MAX        = 1000,
  parameter logic [7:0]  CMD_MOVE       = 8'h01
) (
  input logic                    clk,
  input logic                    rst,
  servo_frame_sequencer_if.slave bus
);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [7:0]    LEN      = 8'd7;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, SEND, GAP} state_t;

  state_t        state;
  logic [3:0]    idx;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    id_q, chk_q;
  logic [15:0]   pos_q, time_q;
  logic [15:0]   pos_acc;
  logic [7:0]    chk_acc;
  logic [7:0]    frame_byte;

  always_comb begin
`ifdef SERVO_POS_CLAMP_EN
    pos_acc = (32'(bus.position) > POS_MAX) ? POS_MAX[15:0] : bus.position;
`else
    pos_acc = bus.position;
`endif
    // 8-bit modulo sum over ID..TIME_H; the two header bytes are excluded
    chk_acc = ~(bus.servo_id + LEN + CMD_MOVE + pos_acc[7:0] + pos_acc[15:8] +
                bus.move_time[7:0] + bus.move_time[15:8]);
  end

  always_comb begin
    case (idx)
      4'd0, 4'd1: frame_byte = 8'h55;
      4'd2:       frame_byte = id_q;
      4'd3:       frame_byte = LEN;
      4'd4:       frame_byte = CMD_MOVE;
      4'd5:       frame_byte = pos_q[7:0];
      4'd6:       frame_byte = pos_q[15:8];
      4'd7:       frame_byte = time_q[7:0];
      4'd8:       frame_byte = time_q[15:8];
      default:    frame_byte = chk_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      to_cnt         <= '0;
      gap_cnt        <= '0;
      id_q           <= '0;
      chk_q          <= '0;
      pos_q          <= '0;
      time_q         <= '0;
      bus.cmd_ready  <= 1'b0;
      bus.tx_wr      <= 1'b0;
      bus.tx_data    <= '0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            id_q          <= bus.servo_id;
            pos_q         <= pos_acc;
            time_q        <= bus.move_time;
            chk_q         <= chk_acc;
            idx           <= '0;
            bus.cmd_ready <= 1'b0;
            state         <= LOAD;
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        LOAD: begin
          // tx_wr rises together with the LAUNCH entry, so the data is already stable
          bus.tx_data <= frame_byte;
          bus.tx_wr   <= 1'b1;
          to_cnt      <= '0;
          state       <= LAUNCH;
        end
        LAUNCH: begin
          if (bus.tx_busy) begin
            state <= SEND;
          end else if (to_cnt == TO_LAST) begin
            bus.tx_wr     <= 1'b0;
            bus.frame_err <= 1'b1;
            state         <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        SEND: begin
          if (!bus.tx_busy) begin
            bus.tx_wr <= 1'b0;
            if (idx == 4'd9) begin
              bus.frame_done <= 1'b1;
              state          <= IDLE;
            end else begin
              idx     <= idx + 4'd1;
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= LOAD;
          else gap_cnt <= gap_cnt + GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_servo_frame_sequencer.sv
// Self-checking bench for servo_frame_sequencer: transmitter model, frame reference model, directed and random frames.
module tb_servo_frame_sequencer;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  servo_frame_sequencer_if bus ();

  servo_frame_sequencer #(
    .GAP_CYCLES    (4),
    .TIMEOUT_CYCLES(TIMEOUT),
    .POS_MAX       (1000),
    .CMD_MOVE      (8'h01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #10 clk = ~clk;

  int unsigned nchk = 0, nerr = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  rx[$];
  logic [7:0]  exp_q[$];
  bit          busy_en = 1'b1;
  int unsigned done_cnt = 0, err_cnt = 0, gap_err = 0, stab_err = 0, pulse_err = 0;

  // Transmitter model: on a tx_wr rising edge capture the byte, raise busy after a short latency, hold it a while.
  initial begin : xmtr
    int unsigned phase, cnt;
    logic wr_q;
    phase = 0; cnt = 0; wr_q = 1'b0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0; bus.tx_busy = 1'b0; wr_q = 1'b0;
      end else begin
        case (phase)
          0: if (bus.tx_wr && !wr_q && busy_en) begin
               rx.push_back(bus.tx_data);
               cnt = $urandom_range(0, 2);
               phase = 1;
             end
          1: if (cnt == 0) begin
               bus.tx_busy = 1'b1;
               cnt = $urandom_range(2, 6);
               phase = 2;
             end else cnt--;
          default: begin
               cnt--;
               if (cnt == 0) begin bus.tx_busy = 1'b0; phase = 0; end
             end
        endcase
        wr_q = bus.tx_wr;
      end
    end
  end

  initial begin : mon
    logic pwr, pdone;
    logic [7:0] pdata;
    int unsigned low_run;
    pwr = 1'b0; pdone = 1'b0; pdata = '0; low_run = 100;
    forever begin
      @(negedge clk);
      if (bus.tx_wr && pwr && bus.tx_data !== pdata) stab_err++;
      if (bus.tx_wr && !pwr) begin
        if (low_run < 3) gap_err++;
        low_run = 0;
      end
      if (!bus.tx_wr) low_run++;
      if (bus.frame_done) begin done_cnt++; if (pdone) pulse_err++; end
      if (bus.frame_err) err_cnt++;
      pwr = bus.tx_wr; pdata = bus.tx_data; pdone = bus.frame_done;
    end
  end

  initial begin : watchdog
    #(20 * 60000);
    $display("FAIL watchdog: simulation did not finish, checks=%0d", nchk);
    $fatal(1, "watchdog expired");
  end

  function automatic void expect_frame(input logic [7:0] id, input logic [15:0] pos,
                                       input logic [15:0] tim);
    int unsigned p, t, sum;
    p = pos; t = tim;
`ifdef SERVO_POS_CLAMP_EN
    if (p > 1000) p = 1000;
`endif
    sum = id + 7 + 1 + (p % 256) + (p / 256) + (t % 256) + (t / 256);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h55);
    exp_q.push_back(id);
    exp_q.push_back(8'd7);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'(p % 256));
    exp_q.push_back(8'(p / 256));
    exp_q.push_back(8'(t % 256));
    exp_q.push_back(8'(t / 256));
    exp_q.push_back(8'(255 - (sum % 256)));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [7:0] id, input logic [15:0] pos, input logic [15:0] tim,
                       input bit keep);
    int unsigned n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.servo_id = id; bus.position = pos; bus.move_time = tim;
    while (!bus.cmd_ready && n < 3000) begin @(negedge clk); n++; end
    check("accept ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    expect_frame(id, pos, tim);
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned target, input string tag);
    int unsigned n;
    n = 0;
    while (done_cnt < target && n < 5000) begin @(negedge clk); n++; end
    check(tag, done_cnt, target);
  endtask

  task automatic cmp_frames(input string tag);
    check({tag, " len"}, rx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
      check($sformatf("%s byte%0d", tag, i), rx[i], exp_q[i]);
    rx.delete();
    exp_q.delete();
  endtask

  initial begin : stim
    int unsigned dexp, n, t0, d0, e0;
    logic [7:0] rid;
    logic [15:0] rpos, rtim;
    bus.cmd_valid = 1'b0; bus.servo_id = '0; bus.position = '0; bus.move_time = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst cmd_ready", bus.cmd_ready, 0);
    check("rst tx_wr", bus.tx_wr, 0);
    check("rst tx_data", bus.tx_data, 8'h00);
    check("rst frame_done", bus.frame_done, 0);
    check("rst frame_err", bus.frame_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready after reset", bus.cmd_ready, 1);

    // Basic frame
    issue(8'h01, 16'd500, 16'd1000, 1'b0);
    wait_done(1, "t1 done");
    check("t1 chk", rx[9], 8'h16);
    cmp_frames("t1");
    dexp = 1;

    // Position above ceiling
    issue(8'h07, 16'd1200, 16'd1000, 1'b0);
    dexp++;
    wait_done(dexp, "t3 done");
`ifdef SERVO_POS_CLAMP_EN
    check("t2 pos_l", rx[5], 8'hE8);
    check("t2 pos_h", rx[6], 8'h03);
`else
    check("t3 pos_l", rx[5], 8'hB0);
    check("t3 pos_h", rx[6], 8'h04);
    check("t3 chk", rx[9], 8'h51);
`endif
    cmp_frames("t3");

    for (int k = 0; k < 6; k++) begin
      rid = 8'($urandom); rpos = 16'($urandom); rtim = 16'($urandom);
      if (k == 0) rpos = 16'hFFFF;
      issue(rid, rpos, rtim, 1'b0);
      dexp++;
      wait_done(dexp, $sformatf("rand%0d done", k));
      cmp_frames($sformatf("rand%0d", k));
    end

    // Transmitter that never goes busy
    busy_en = 1'b0;
    issue(8'h22, 16'd10, 16'd20, 1'b0);
    exp_q.delete();
    n = 0;
    while (!bus.tx_wr && n < 100) begin @(negedge clk); n++; end
    t0 = cyc;
    n = 0;
    while (!bus.frame_err && n < 200) begin @(negedge clk); n++; end
    check("t4 err latency", cyc - t0, TIMEOUT);
    check("t4 tx_wr low", bus.tx_wr, 0);
    check("t4 ready in err cycle", bus.cmd_ready, 0);
    @(negedge clk);
    check("t4 ready next", bus.cmd_ready, 1);
    check("t4 err pulse width", bus.frame_err, 0);
    check("t4 err count", err_cnt, 1);
    check("t4 no bytes", rx.size(), 0);
    check("t4 no done", done_cnt, dexp);
    busy_en = 1'b1;

    // cmd_valid held high across two frames
    issue(8'h0A, 16'd300, 16'd40, 1'b1);
    issue(8'h0B, 16'd301, 16'd41, 1'b0);
    dexp += 2;
    wait_done(dexp, "t5 done");
    cmp_frames("t5");
    check("t5 gap", gap_err, 0);
    check("t5 stable", stab_err, 0);

    // Reset during byte 4
    issue(8'h33, 16'd777, 16'd555, 1'b0);
    n = 0;
    while (rx.size() < 4 && n < 2000) begin @(negedge clk); n++; end
    check("t6 reached byte4", rx.size(), 4);
    d0 = done_cnt; e0 = err_cnt;
    #3 rst = 1'b1;
    #1;
    check("t6 async tx_wr", bus.tx_wr, 0);
    check("t6 async ready", bus.cmd_ready, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6 no done", done_cnt, d0);
    check("t6 no err", err_cnt, e0);
    rx.delete();
    exp_q.delete();
    issue(8'h44, 16'd900, 16'd100, 1'b0);
    dexp++;
    wait_done(dexp, "t6 done");
    cmp_frames("t6");

    check("final stable", stab_err, 0);
    check("final gap", gap_err, 0);
    check("final pulse", pulse_err, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
